// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle of the bit-serial add/sub sequencer.
// The master issues operands and start; the slave returns status, result and flags.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell is reused LSB-first for WIDTH cycles,
// with the sum collected in a right-shifting result register.
module serial_addsub_fa (
  input  logic a,
  input  logic bmux,
  input  logic cin,
  output logic sum,
  output logic co
);
  assign sum = a ^ bmux ^ cin;
  assign co  = (a & bmux) | (cin & (a ^ bmux));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  serial_addsub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic             sum;
  logic             co;
  logic [WIDTH-1:0] result_d;

  serial_addsub_fa u_fa (
    .a    (a_sh_q[0]),
    .bmux (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (sum),
    .co   (co)
  );

  assign result_d = {sum, result_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      msb_cin_q   <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.sub ? ~bus.b : bus.b;
            carry_q  <= bus.sub;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          carry_q  <= co;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_PRE) begin
            msb_cin_q <= co;
          end
          if (cnt_q == CNT_LAST) begin
            // Flags are taken from the final cell outputs so they land with done.
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            carry_out_q <= co;
            overflow_q  <= msb_cin_q ^ co;
            zero_q      <= (result_d == '0);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl at WIDTH 8, 32 and 2,
// checked against an arithmetic reference model.
module tb_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.WIDTH(8))  if8  ();
  serial_addsub_ctrl_if #(.WIDTH(32)) if32 ();
  serial_addsub_ctrl_if #(.WIDTH(2))  if2  ();

  serial_addsub_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_addsub_ctrl #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  serial_addsub_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Reference: unsigned sum/difference modulo 2^w, carry as unsigned overflow/no-borrow,
  // overflow as the signed result falling outside the w-bit two's-complement range.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic sv, output logic [31:0] r, output logic c,
                                output logic o, output logic z);
    longint unsigned md, ua, ub, full;
    longint sa, sb, s, half;
    md   = 64'd1 << w;
    half = longint'(md / 2);
    ua   = longint'(av & mask_of(w));
    ub   = longint'(bv & mask_of(w));
    if (!sv) begin
      full = ua + ub;
      c    = (full >= md);
    end else begin
      full = ua + md - ub;
      c    = (ua >= ub);
    end
    r  = 32'(full % md);
    sa = (longint'(ua) >= half) ? longint'(ua) - longint'(md) : longint'(ua);
    sb = (longint'(ub) >= half) ? longint'(ub) - longint'(md) : longint'(ub);
    s  = sv ? sa - sb : sa + sb;
    o  = (s < -half) || (s >= half);
    z  = (r == 32'd0);
  endfunction

  task automatic set_inputs(input int w, input logic st, input logic [31:0] av,
                            input logic [31:0] bv, input logic sv);
    case (w)
      8:       begin if8.start = st;  if8.a = av[7:0];  if8.b = bv[7:0];  if8.sub = sv;  end
      32:      begin if32.start = st; if32.a = av;      if32.b = bv;      if32.sub = sv; end
      default: begin if2.start = st;  if2.a = av[1:0];  if2.b = bv[1:0];  if2.sub = sv;  end
    endcase
  endtask

  function automatic logic [31:0] get_result(input int w);
    case (w)
      8:       return {24'd0, if8.result};
      32:      return if32.result;
      default: return {30'd0, if2.result};
    endcase
  endfunction

  // {busy, done, carry_out, overflow, zero}
  function automatic logic [4:0] get_flags(input int w);
    case (w)
      8:       return {if8.busy, if8.done, if8.carry_out, if8.overflow, if8.zero};
      32:      return {if32.busy, if32.done, if32.carry_out, if32.overflow, if32.zero};
      default: return {if2.busy, if2.done, if2.carry_out, if2.overflow, if2.zero};
    endcase
  endfunction

  task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv);
    logic [31:0] er;
    logic        ec, eo, ez;
    logic [4:0]  f;
    int          lat, busy_cnt;
    model(w, av, bv, sv, er, ec, eo, ez);
    set_inputs(w, 1'b1, av, bv, sv);
    @(posedge clk); #1;
    set_inputs(w, 1'b0, $urandom, $urandom, 1'($urandom));
    lat = 1;
    busy_cnt = 0;
    f = get_flags(w);
    while (!f[3] && lat <= w + 4) begin
      if (f[4]) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      f = get_flags(w);
    end
    check_eq("latency", 32'(lat), 32'(w + 1));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(w));
    check_eq("busy_at_done", 32'(f[4]), 32'd0);
    check_eq("result", get_result(w), er);
    check_eq("carry_out", 32'(f[2]), 32'(ec));
    check_eq("overflow", 32'(f[1]), 32'(eo));
    check_eq("zero", 32'(f[0]), 32'(ez));
    $display("op w=%0d a=0x%0h b=0x%0h sub=%0d -> result=0x%0h c=%0d v=%0d z=%0d lat=%0d",
             w, av & mask_of(w), bv & mask_of(w), sv, get_result(w), f[2], f[1], f[0], lat);
    @(posedge clk); #1;
    f = get_flags(w);
    check_eq("done_pulse", 32'(f[3]), 32'd0);
    check_eq("result_hold", get_result(w), er);
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return mask_of(w);
      2:       return 32'd1 << (w - 1);
      3:       return mask_of(w) >> 1;
      default: return $urandom & mask_of(w);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] f;
    int         n_done;

    rst_n = 1'b0;
    set_inputs(8, 1'b0, 0, 0, 1'b0);
    set_inputs(32, 1'b0, 0, 0, 1'b0);
    set_inputs(2, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flags8", 32'(get_flags(8)), 32'd0);
    check_eq("rst_result8", get_result(8), 32'd0);
    check_eq("rst_flags32", 32'(get_flags(32)), 32'd0);
    check_eq("rst_flags2", 32'(get_flags(2)), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=8 cases.
    do_op(8, 32'd100, 32'd27, 1'b0);
    check_eq("add127_result", get_result(8), 32'd127);
    do_op(8, 32'h7F, 32'h01, 1'b0);
    do_op(8, 32'hFF, 32'h01, 1'b0);
    do_op(8, 32'd5, 32'd7, 1'b1);
    check_eq("sub_borrow_result", get_result(8), 32'hFE);
    do_op(8, 32'h80, 32'h01, 1'b1);

    // Starts during RUN and DONE are ignored; the next IDLE cycle accepts.
    set_inputs(8, 1'b1, 32'd100, 32'd27, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      set_inputs(8, (c == 3 || c == 9), $urandom, $urandom, 1'($urandom));
      f = get_flags(8);
      if (c == 9) begin
        check_eq("ign_done", 32'(f[3]), 32'd1);
        check_eq("ign_result", get_result(8), 32'd127);
      end
      @(posedge clk); #1;
    end
    set_inputs(8, 1'b0, 0, 0, 1'b0);
    f = get_flags(8);
    check_eq("ign_busy", 32'(f[4]), 32'd0);
    check_eq("ign_hold", get_result(8), 32'd127);
    do_op(8, 32'h80, 32'h01, 1'b1);

    // Reset in the middle of RUN aborts without a done pulse.
    set_inputs(8, 1'b1, 32'h0F, 32'h00, 1'b0);
    @(posedge clk); #1;
    set_inputs(8, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_result", get_result(8), 32'hE0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_flags", 32'(get_flags(8)), 32'd0);
    check_eq("mid_rst_result", get_result(8), 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      f = get_flags(8);
      if (f[3] || f[4]) n_done++;
      @(posedge clk); #1;
    end
    check_eq("no_done_after_rst", 32'(n_done), 32'd0);

    // Reset and start on the same edge: reset wins.
    set_inputs(8, 1'b1, 32'h12, 32'h34, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_inputs(8, 1'b0, 0, 0, 1'b0);
    f = get_flags(8);
    check_eq("rst_start_busy", 32'(f[4]), 32'd0);
    @(posedge clk); #1;
    f = get_flags(8);
    check_eq("rst_start_busy2", 32'(f[4]), 32'd0);
    do_op(8, 32'h12, 32'h34, 1'b0);
    do_op(8, 32'h34, 32'h12, 1'b1);

    for (int i = 0; i < 100; i++) do_op(8, pick(8), pick(8), 1'($urandom));
    for (int i = 0; i < 600; i++) do_op(32, pick(32), pick(32), 1'($urandom));
    for (int i = 0; i < 600; i++) do_op(2, pick(2), pick(2), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
